// File: rtl/onewire_data_writer.sv
// Master-side 1-Wire write-slot generator: serialises a 64-bit word LSB first,
// one fixed-length write slot per bit, driving an active-high pull-down enable.
module onewire_data_writer #(
    parameter int unsigned SLOT_CYCLES = 61,
    parameter int unsigned LOW1_CYCLES = 6,
    parameter int unsigned LOW0_CYCLES = 56,
    parameter int unsigned NUM_BITS    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_data_write,
    input  logic [63:0] data,
    output logic        bus_drive_low,
    output logic        busy,
    output logic        done_writing_data,
    output logic [6:0]  bit_index
);

    localparam int unsigned CntW = $clog2(SLOT_CYCLES);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSlot = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [CntW-1:0] CntLast = CntW'(SLOT_CYCLES - 1);
    localparam logic [CntW-1:0] Low1Len = CntW'(LOW1_CYCLES);
    localparam logic [CntW-1:0] Low0Len = CntW'(LOW0_CYCLES);
    localparam logic [6:0]      BitLast = 7'(NUM_BITS - 1);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     shift_q, shift_d;
    logic [6:0]      bit_q, bit_d;
    logic            bus_q, bus_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CntW-1:0] low_len;

    assign low_len = shift_q[0] ? Low1Len : Low0Len;

    // Outputs are the registered next values, so bus_d describes the level for
    // the cycle that follows the edge on which it is loaded.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        bus_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (en_data_write) begin
                    state_d = StSlot;
                    shift_d = data;
                    bit_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    bus_d   = 1'b1;
                end
            end

            StSlot: begin
                if (!en_data_write) begin
                    state_d = StIdle;
                    bit_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (bit_q == BitLast) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[63:1]};
                        bit_d   = bit_q + 7'd1;
                        bus_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    bus_d = (cnt_d < low_len);
                end
            end

            StDone: begin
                busy_d = 1'b0;
                if (!en_data_write) begin
                    state_d = StIdle;
                    done_d  = 1'b0;
                    bit_d   = '0;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                bit_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            bus_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            bus_q   <= bus_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus_drive_low     = bus_q;
    assign busy              = busy_q;
    assign done_writing_data = done_q;
    assign bit_index         = bit_q;

endmodule

// File: tb/tb_onewire_data_writer.sv
// Self-checking bench for onewire_data_writer: the expected bus waveform is
// derived per cycle from slot arithmetic and a count-30 sampling reader model.
module tb_onewire_data_writer;

    localparam int SLOT = 61;
    localparam int LOW1 = 6;
    localparam int LOW0 = 56;
    localparam int NB   = 64;
    localparam int XFER = NB * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_data_write;
    logic [63:0] data;
    logic        bus_drive_low;
    logic        busy;
    logic        done_writing_data;
    logic [6:0]  bit_index;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    onewire_data_writer dut (
        .clk               (clk),
        .rst               (rst),
        .en_data_write     (en_data_write),
        .data              (data),
        .bus_drive_low     (bus_drive_low),
        .busy              (busy),
        .done_writing_data (done_writing_data),
        .bit_index         (bit_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // k counts cycles after the accepting edge; bit k/SLOT, slot count k%SLOT.
    function automatic logic exp_bus(input logic [63:0] w, input int k);
        int b;
        int c;
        b = k / SLOT;
        c = k % SLOT;
        return (c < (w[b] ? LOW1 : LOW0));
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".bus"},  64'(bus_drive_low), 64'd0);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".done"}, 64'(done_writing_data), 64'd0);
        check({tag, ".bit"},  64'(bit_index), 64'd0);
    endtask

    // Runs a transfer of w. stop_k >= 0 interrupts at that cycle with an abort
    // (en low) or a reset. scramble keeps changing data after acceptance.
    task automatic transfer(input logic [63:0] w, input int stop_k, input bit use_rst,
                            input bit scramble);
        logic [63:0] rx;
        rx = '0;
        data = w;
        en_data_write = 1'b1;
        step();
        for (int k = 0; k < XFER; k++) begin
            check("bus",  64'(bus_drive_low), 64'(exp_bus(w, k)));
            check("busy", 64'(busy), 64'd1);
            check("done", 64'(done_writing_data), 64'd0);
            check("bit_index", 64'(bit_index), 64'(k / SLOT));
            if (k % SLOT == 30) rx[k / SLOT] = ~bus_drive_low;
            if (scramble) data = (k == 0) ? ~w : {$urandom, $urandom};
            if (k == stop_k) begin
                if (use_rst) rst = 1'b1;
                else en_data_write = 1'b0;
                step();
                check_idle(use_rst ? "after_rst" : "after_abort");
                rst = 1'b0;
                return;
            end
            step();
        end
        check("end.done", 64'(done_writing_data), 64'd1);
        check("end.busy", 64'(busy), 64'd0);
        check("end.bus",  64'(bus_drive_low), 64'd0);
        check("loopback", rx, w);
    endtask

    task automatic release_en();
        en_data_write = 1'b0;
        step();
        check_idle("release");
    endtask

    initial begin
        logic [63:0] w;
        rst = 1'b1;
        en_data_write = 1'b0;
        data = '0;
        repeat (3) step();
        check_idle("reset");
        rst = 1'b0;
        step();
        check_idle("idle");

        // Single '1' in bit 0, then hold en after completion
        transfer(64'h0000_0000_0000_0001, -1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step();
            check("hold.done", 64'(done_writing_data), 64'd1);
            check("hold.bus",  64'(bus_drive_low), 64'd0);
            check("hold.busy", 64'(busy), 64'd0);
        end
        release_en();

        transfer(64'hA5A5_5A5A_0123_FEDC, -1, 1'b0, 1'b0);
        release_en();

        // Data changes after acceptance must be ignored
        transfer(64'h0, -1, 1'b0, 1'b1);
        release_en();

        // Abort in slot 10 at count 3, then restart from bit 0
        transfer({$urandom, $urandom}, 10 * SLOT + 3, 1'b0, 1'b0);
        transfer({$urandom, $urandom}, -1, 1'b0, 1'b0);
        release_en();

        // Reset in slot 5 while the bus is pulled low, en kept high
        transfer({$urandom, $urandom}, 5 * SLOT + 2, 1'b1, 1'b0);
        transfer({$urandom, $urandom}, -1, 1'b0, 1'b0);
        release_en();

        for (int t = 0; t < 2; t++) begin
            w = {$urandom, $urandom};
            transfer(w, -1, 1'b0, 1'($urandom_range(0, 1)));
            release_en();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
